// File: rtl/pooling_layer_scheduler_if.sv
// pooling_layer_scheduler_if
//   Bundles the scheduler's control and status signals.
//   master : top-level controller / upstream side (drives start, in_valid)
//   slave  : the scheduler itself
//   start, in_valid         : pass start pulse, upstream row available
//   in_ready                : scheduler can take a row this cycle
//   pool_valid/_feature_*   : row issued to the pooling datapath
//   out_row_valid/_idx      : pooled output row completed
//   busy, done              : pass in progress, end-of-pass pulse
interface pooling_layer_scheduler_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       pool_valid;
  logic [1:0] pool_feature_idx;
  logic [2:0] pool_feature_row;
  logic       out_row_valid;
  logic [1:0] out_feature_idx;
  logic [1:0] out_row_idx;
  logic       busy;
  logic       done;

  modport master (
    output start, in_valid,
    input  in_ready, pool_valid, pool_feature_idx, pool_feature_row,
    input  out_row_valid, out_feature_idx, out_row_idx, busy, done
  );

  modport slave (
    input  start, in_valid,
    output in_ready, pool_valid, pool_feature_idx, pool_feature_row,
    output out_row_valid, out_feature_idx, out_row_idx, busy, done
  );
endinterface

// File: rtl/pooling_layer_scheduler.sv
// pooling_layer_scheduler
//   Sequences one pooling layer pass: accepts conv output rows over a
//   valid/ready handshake, issues them to the pooling datapath no faster
//   than one per ROW_GAP cycles, tracks pooled-row completion through an
//   OUT_LATENCY-deep pipeline and pulses done at the end of the pass.
// Ports
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : pooling_layer_scheduler_if.slave (see interface header)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start, in_ready low
// S_RUN   | in_ready high, a row is taken on in_valid
// S_GAP   | spacing rows to respect pooling array occupancy
// S_DRAIN | all rows taken, waiting for last pooled rows to complete
// S_DONE  | done pulse, back to idle next cycle
module pooling_layer_scheduler #(
  parameter int FEATURE_NUM  = 3,
  parameter int FEATURE_ROWS = 6,
  parameter int ROW_GAP      = 4,
  parameter int OUT_LATENCY  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pooling_layer_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

  // Only odd input rows complete a pooled row, so the pipeline tracks just
  // those; the payload is loaded only alongside a fire so the tail stage
  // holds the last reported indices between pulses.
  typedef struct packed {
    logic       fire;
    logic [1:0] feat;
    logic [1:0] orow;
  } cmpl_t;

  state_t     r_state;
  logic [1:0] r_feat;
  logic [2:0] r_row;
  logic [7:0] r_gap;
  logic       r_in_ready;
  logic       r_pool_valid;
  logic [1:0] r_pool_feat;
  logic [2:0] r_pool_row;
  logic       r_busy;
  logic       r_done;

  cmpl_t      r_pipe  [OUT_LATENCY];
  cmpl_t      w_chain [OUT_LATENCY];
  logic       w_drained;
  logic       w_accept;
  logic       w_last_row;
  logic       w_last_feat;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_last_row  = (r_row == 3'(FEATURE_ROWS - 1));
  assign w_last_feat = (r_feat == 2'(FEATURE_NUM - 1));

  always_comb begin
    w_chain[0] = '{fire: r_pool_valid & r_pool_row[0],
                   feat: r_pool_feat,
                   orow: r_pool_row[2:1]};
    for (int k = 1; k < OUT_LATENCY; k++) begin
      w_chain[k] = r_pipe[k-1];
    end
  end

  // The tail stage may still be firing; DONE follows it by one cycle, so
  // only the stages feeding the tail (and the row in flight) must be empty.
  always_comb begin
    w_drained = !w_chain[0].fire;
    for (int k = 0; k < OUT_LATENCY - 1; k++) begin
      if (r_pipe[k].fire) w_drained = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_feat       <= '0;
      r_row        <= '0;
      r_gap        <= '0;
      r_in_ready   <= 1'b0;
      r_pool_valid <= 1'b0;
      r_pool_feat  <= '0;
      r_pool_row   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_pool_valid <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_feat     <= '0;
            r_row      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_pool_valid <= 1'b1;
            r_pool_feat  <= r_feat;
            r_pool_row   <= r_row;
            if (w_last_row) begin
              r_row  <= '0;
              r_feat <= r_feat + 2'd1;
            end else begin
              r_row  <= r_row + 3'd1;
            end
            if (w_last_row && w_last_feat) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end else if (ROW_GAP > 1) begin
              // accept cycle plus ROW_GAP-2 decrements plus the exit cycle
              r_state    <= S_GAP;
              r_gap      <= 8'(ROW_GAP - 2);
              r_in_ready <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (r_gap == 8'd0) begin
            r_state    <= S_RUN;
            r_in_ready <= 1'b1;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OUT_LATENCY; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      for (int k = 0; k < OUT_LATENCY; k++) begin
        r_pipe[k].fire <= w_chain[k].fire;
        if (w_chain[k].fire) begin
          r_pipe[k].feat <= w_chain[k].feat;
          r_pipe[k].orow <= w_chain[k].orow;
        end
      end
    end
  end

  assign bus.in_ready         = r_in_ready;
  assign bus.pool_valid       = r_pool_valid;
  assign bus.pool_feature_idx = r_pool_feat;
  assign bus.pool_feature_row = r_pool_row;
  assign bus.out_row_valid    = r_pipe[OUT_LATENCY-1].fire;
  assign bus.out_feature_idx  = r_pipe[OUT_LATENCY-1].feat;
  assign bus.out_row_idx      = r_pipe[OUT_LATENCY-1].orow;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;

endmodule

// File: tb/tb_pooling_layer_scheduler.sv
// tb_pooling_layer_scheduler
//   Directed bench for pooling_layer_scheduler. dut1 uses the default
//   parameters, dut2 runs with ROW_GAP=1 / OUT_LATENCY=1. Outputs are
//   sampled on the falling edge; inputs are driven there too.
module tb_pooling_layer_scheduler;
  localparam int FN    = 3;
  localparam int FR    = 6;
  localparam int G1    = 4;
  localparam int L1    = 3;
  localparam int TOTAL = FN * FR;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pooling_layer_scheduler_if bus1 ();
  pooling_layer_scheduler_if bus2 ();

  pooling_layer_scheduler #(
    .FEATURE_NUM(FN), .FEATURE_ROWS(FR), .ROW_GAP(G1), .OUT_LATENCY(L1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  pooling_layer_scheduler #(
    .FEATURE_NUM(FN), .FEATURE_ROWS(FR), .ROW_GAP(1), .OUT_LATENCY(1)
  ) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int errors = 0;
  int checks = 0;
  logic [1:0] last_f = 2'd0;
  logic [1:0] last_r = 2'd0;
  bit         eo_v [0:1023];
  logic [1:0] eo_f [0:1023];
  logic [1:0] eo_r [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dut1"}, {bus1.in_ready, bus1.pool_valid, bus1.pool_feature_idx,
         bus1.pool_feature_row, bus1.out_row_valid, bus1.out_feature_idx,
         bus1.out_row_idx, bus1.busy, bus1.done}, 32'd0);
    chk({tag, "_dut2"}, {bus2.in_ready, bus2.pool_valid, bus2.pool_feature_idx,
         bus2.pool_feature_row, bus2.out_row_valid, bus2.out_feature_idx,
         bus2.out_row_idx, bus2.busy, bus2.done}, 32'd0);
  endtask

  // One full pass on dut1. pct: in_valid probability in percent (100 = held).
  // poke: pulse start repeatedly while the pass is in progress.
  task automatic run_pass(input int pct, input bit poke,
                          output int o_first_pool, output int o_first_out,
                          output int o_last_out, output int o_done_at,
                          output int o_busy_fall);
    int  n_acc = 0, next_ok = 1, done_cyc = 100000;
    int  n_pool = 0, n_out = 0, n_done = 0;
    bit  pend_pool = 0, exp_ready, acc;
    logic [1:0] pend_f = 0;
    logic [2:0] pend_r = 0;
    o_first_pool = -1; o_first_out = -1; o_last_out = -1;
    o_done_at = -1; o_busy_fall = -1;
    for (int i = 0; i < 1024; i++) eo_v[i] = 1'b0;

    @(negedge clk);
    chk("pre_busy", bus1.busy, 1'b0);
    chk("pre_ready", bus1.in_ready, 1'b0);
    bus1.start    = 1'b1;
    bus1.in_valid = 1'b1;

    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      bus1.start = poke && (c < done_cyc) && ((c % 7) == 3);
      exp_ready = (n_acc < TOTAL) && (c >= next_ok);
      chk("in_ready", bus1.in_ready, exp_ready);
      chk("pool_valid", bus1.pool_valid, pend_pool);
      if (pend_pool) begin
        chk("pool_feature_idx", bus1.pool_feature_idx, pend_f);
        chk("pool_feature_row", bus1.pool_feature_row, pend_r);
      end
      if (bus1.pool_valid) begin
        n_pool++;
        if (o_first_pool < 0) o_first_pool = c;
      end
      chk("out_row_valid", bus1.out_row_valid, eo_v[c]);
      if (eo_v[c]) begin
        last_f = eo_f[c];
        last_r = eo_r[c];
      end
      chk("out_feature_idx", bus1.out_feature_idx, last_f);
      chk("out_row_idx", bus1.out_row_idx, last_r);
      if (bus1.out_row_valid) begin
        n_out++;
        if (o_first_out < 0) o_first_out = c;
        o_last_out = c;
      end
      chk("done", bus1.done, c == done_cyc);
      if (bus1.done) begin
        n_done++;
        o_done_at = c;
      end
      chk("busy", bus1.busy, c <= done_cyc);
      if (!bus1.busy && o_busy_fall < 0) o_busy_fall = c;
      if (c == done_cyc + 2) break;

      bus1.in_valid = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      acc = bus1.in_valid && exp_ready;
      pend_pool = acc;
      if (acc) begin
        pend_f = 2'(n_acc / FR);
        pend_r = 3'(n_acc % FR);
        if (pend_r[0]) begin
          eo_v[c+1+L1] = 1'b1;
          eo_f[c+1+L1] = pend_f;
          eo_r[c+1+L1] = pend_r[2:1];
        end
        n_acc++;
        next_ok = c + G1;
        if (n_acc == TOTAL) done_cyc = c + 2 + L1;
      end
    end
    bus1.start    = 1'b0;
    bus1.in_valid = 1'b0;
    chk("n_pool", n_pool, TOTAL);
    chk("n_out", n_out, TOTAL / 2);
    chk("n_done", n_done, 1);

    // in_valid while idle must not be taken
    bus1.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_ready", bus1.in_ready, 1'b0);
      chk("idle_pool_valid", bus1.pool_valid, 1'b0);
      chk("idle_busy", bus1.busy, 1'b0);
    end
    bus1.in_valid = 1'b0;
  endtask

  initial begin
    int fp, fo, lo, da, bf;
    bus1.start = 0; bus1.in_valid = 0;
    bus2.start = 0; bus2.in_valid = 0;

    // reset held with random stimulus, including start
    repeat (4) begin
      @(negedge clk);
      bus1.start    = 1'($urandom_range(1));
      bus1.in_valid = 1'($urandom_range(1));
      bus2.start    = 1'($urandom_range(1));
      bus2.in_valid = 1'($urandom_range(1));
      #1 chk_zero("reset_outputs");
    end
    @(negedge clk);
    bus1.start = 0; bus1.in_valid = 0;
    bus2.start = 0; bus2.in_valid = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_reset");

    // full pass, in_valid held high
    run_pass(100, 1'b0, fp, fo, lo, da, bf);
    chk("full_first_pool", fp, 2);
    chk("full_first_out", fo, 9);
    chk("full_last_out", lo, 73);
    chk("full_done_at", da, 74);
    chk("full_busy_fall", bf, 75);

    // sparse upstream with start pulses during the pass
    run_pass(30, 1'b1, fp, fo, lo, da, bf);
    chk("sparse_busy_after_done", bf, da + 1);

    // asynchronous reset mid-pass: row (1,3) is accepted at cycle 37
    @(negedge clk);
    bus1.start = 1'b1; bus1.in_valid = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      bus1.start = 1'b0;
    end
    chk("mid_pool_valid", bus1.pool_valid, 1'b1);
    chk("mid_pool_feat", bus1.pool_feature_idx, 2'd1);
    chk("mid_pool_row", bus1.pool_feature_row, 3'd3);
    #1 rst_n = 1'b0;
    last_f = 2'd0; last_r = 2'd0;
    #1 chk_zero("mid_reset");
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset_held");
    rst_n = 1'b1;

    // restart after the aborted pass must begin at (0,0) with no stale rows
    run_pass(100, 1'b1, fp, fo, lo, da, bf);
    chk("restart_first_out", fo, 9);
    chk("restart_done_at", da, 74);

    // ROW_GAP=1, OUT_LATENCY=1
    @(negedge clk);
    bus2.start = 1'b1; bus2.in_valid = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      bus2.start = 1'b0;
      chk("g1_in_ready", bus2.in_ready, (c >= 1) && (c <= 18));
      chk("g1_pool_valid", bus2.pool_valid, (c >= 2) && (c <= 19));
      if (c >= 2 && c <= 19) begin
        chk("g1_pool_feat", bus2.pool_feature_idx, (c - 2) / 6);
        chk("g1_pool_row", bus2.pool_feature_row, (c - 2) % 6);
      end
      chk("g1_out_row_valid", bus2.out_row_valid, (c >= 4) && (c <= 20) && ((c % 2) == 0));
      if (c >= 4 && c <= 20 && (c % 2) == 0) begin
        chk("g1_out_feat", bus2.out_feature_idx, (c - 3) / 6);
        chk("g1_out_row", bus2.out_row_idx, ((c - 3) % 6) / 2);
      end
      chk("g1_done", bus2.done, c == 21);
      chk("g1_busy", bus2.busy, c <= 21);
    end
    bus2.in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
